// File: rtl/ledvideo_scan_ctrl.sv
// ledvideo_scan_ctrl
// Row/bit-plane scan scheduler for the LED panel output path.
// Walks (row, plane) through the framebuffer with a blit start/done
// handshake, overlaps the shift of the next plane with the display of the
// current one, and swaps framebuffers at frame boundaries.
//
// Optional feature: define LEDVIDEO_BLIT_TIMEOUT_EN to enable the blit
// watchdog (sticky blit_err plus automatic re-request of the same plane).
// Without it blit_err is tied low and SHIFT waits indefinitely.
module ledvideo_scan_ctrl #(
  parameter int ROW_BITS   = 4,
  parameter int PLANE_BITS = 3,
  parameter int BASE_ON    = 8,
  parameter int TIMER_BITS = 24,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  enable,
  input  logic                  frame_ready,
  input  logic                  blit_done,
  output logic                  blit_start,
  output logic [ROW_BITS-1:0]   blit_row,
  output logic [PLANE_BITS-1:0] blit_plane,
  output logic                  buf_sel,
  output logic                  frame_swap,
  output logic [ROW_BITS-1:0]   panel_addr,
  output logic                  panel_lat,
  output logic                  panel_oe_n,
  output logic [15:0]           frame_count,
  output logic                  blit_err
);

  localparam int IDX_BITS = ROW_BITS + PLANE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT,
    ST_BLANK,
    ST_LATCH,
    ST_DRAIN
  } state_t;

  state_t                state_reg;
  logic [TIMER_BITS-1:0] timer_reg;
  logic [TIMER_BITS-1:0] timer_next;
  logic [TIMER_BITS-1:0] on_time;
  logic                  disp_last;
  logic [IDX_BITS-1:0]   idx_cur;
  logic [IDX_BITS-1:0]   idx_inc;
  logic                  idx_last;
  logic                  wd_fire;

  // The display timer free-runs down to zero in every state.
  assign timer_next = (timer_reg == '0) ? '0 : timer_reg - 1'b1;

  // "Display is over" is judged on the value the timer takes at this edge,
  // so BLANK lands on the first dark cycle and the dark gap between two
  // back-to-back displays is exactly BLANK + LATCH.
  assign disp_last = (timer_next == '0);

  // Row and plane form one counter with the plane in the low bits, which
  // gives plane-fastest ordering and the wrap to (0,0) for free.
  assign idx_cur  = {blit_row, blit_plane};
  assign idx_inc  = idx_cur + 1'b1;
  assign idx_last = &idx_cur;

  // Binary-weighted on-time of the plane that has just been shifted.
  assign on_time = TIMER_BITS'(BASE_ON) << blit_plane;

`ifdef LEDVIDEO_BLIT_TIMEOUT_EN
  logic [15:0] wd_cnt_reg;

  // Fires on the last cycle of the allowed wait when no done has arrived.
  assign wd_fire = (state_reg == ST_SHIFT) && !blit_done &&
                   (wd_cnt_reg == 16'(TIMEOUT - 1));

  // Watchdog counts SHIFT cycles since the latest blit_start; it is zero in
  // every cycle that carries a blit_start pulse.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wd_cnt_reg <= '0;
    end else if (state_reg != ST_SHIFT || wd_fire) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 16'd1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      blit_err <= 1'b0;
    end else if (wd_fire) begin
      blit_err <= 1'b1;
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign blit_err = 1'b0;
`endif

  // Scan sequencer: state, index, timer and all panel/blit outputs.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      blit_start  <= 1'b0;
      blit_row    <= '0;
      blit_plane  <= '0;
      buf_sel     <= 1'b0;
      frame_swap  <= 1'b0;
      panel_addr  <= '0;
      panel_lat   <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_count <= '0;
    end else begin
      blit_start <= 1'b0;
      frame_swap <= 1'b0;
      panel_lat  <= 1'b0;
      timer_reg  <= timer_next;
      panel_oe_n <= disp_last;

      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg  <= ST_SHIFT;
            blit_start <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (blit_done) begin
            state_reg <= disp_last ? ST_BLANK : ST_WAIT;
          end else if (wd_fire) begin
            // Same row/plane is re-requested; index is left untouched.
            blit_start <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (disp_last) begin
            state_reg <= ST_BLANK;
          end
        end

        ST_BLANK: begin
          // Panel is dark here, so the row address can move safely.
          panel_addr <= blit_row;
          panel_lat  <= 1'b1;
          state_reg  <= ST_LATCH;
        end

        ST_LATCH: begin
          timer_reg                <= on_time;
          panel_oe_n               <= (on_time == '0);
          {blit_row, blit_plane}   <= idx_inc;
          if (idx_last) begin
            frame_count <= frame_count + 16'd1;
            if (frame_ready) begin
              buf_sel    <= ~buf_sel;
              frame_swap <= 1'b1;
            end
          end
          if (enable) begin
            state_reg  <= ST_SHIFT;
            blit_start <= 1'b1;
          end else begin
            state_reg <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (disp_last) begin
            state_reg  <= ST_IDLE;
            blit_row   <= '0;
            blit_plane <= '0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ledvideo_scan_ctrl.sv
// Testbench for ledvideo_scan_ctrl (ROW_BITS=1, PLANE_BITS=2, BASE_ON=2).
// A timeline model computes, per plane, start/done/blank/latch/display
// cycles with plain arithmetic; the bench then drives the precomputed
// inputs and compares every output on every cycle.
module tb_ledvideo_scan_ctrl;

  localparam int ROW_BITS   = 1;
  localparam int PLANE_BITS = 2;
  localparam int BASE_ON    = 2;
  localparam int TIMER_BITS = 8;
  localparam int TIMEOUT    = 64;
  localparam int MAXC       = 2048;
  localparam int NSCEN      = 6;

  logic                  core_clk = 1'b0;
  logic                  core_rst;
  logic                  enable;
  logic                  frame_ready;
  logic                  blit_done;
  logic                  blit_start;
  logic [ROW_BITS-1:0]   blit_row;
  logic [PLANE_BITS-1:0] blit_plane;
  logic                  buf_sel;
  logic                  frame_swap;
  logic [ROW_BITS-1:0]   panel_addr;
  logic                  panel_lat;
  logic                  panel_oe_n;
  logic [15:0]           frame_count;
  logic                  blit_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 core_clk = ~core_clk;

  ledvideo_scan_ctrl #(
    .ROW_BITS  (ROW_BITS),
    .PLANE_BITS(PLANE_BITS),
    .BASE_ON   (BASE_ON),
    .TIMER_BITS(TIMER_BITS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .enable     (enable),
    .frame_ready(frame_ready),
    .blit_done  (blit_done),
    .blit_start (blit_start),
    .blit_row   (blit_row),
    .blit_plane (blit_plane),
    .buf_sel    (buf_sel),
    .frame_swap (frame_swap),
    .panel_addr (panel_addr),
    .panel_lat  (panel_lat),
    .panel_oe_n (panel_oe_n),
    .frame_count(frame_count),
    .blit_err   (blit_err)
  );

  // Scenario record: inputs (plane counts per enable burst, responder delay
  // where 0 means random 1..12, frame_ready mode 0/1/2=random, spurious
  // done pulses) and expected totals.
  typedef struct {
    int n1;
    int n2;
    int dly;
    int fr_mode;
    bit spur;
    int exp_starts;
    int exp_lats;
    int exp_fc;
  } scen_t;

  scen_t tbl[NSCEN];

  int exp_start[MAXC];
  int exp_lat[MAXC];
  int exp_swap[MAXC];
  int exp_oe_n[MAXC];
  int exp_idx[MAXC];
  int exp_addr[MAXC];
  int exp_fc[MAXC];
  int exp_buf[MAXC];
  bit drv_en[MAXC];
  bit drv_done[MAXC];
  bit drv_fr[MAXC];
  bit in_shift[MAXC];
  int run_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [25:0] pack(input int st, input int idx, input int bf, input int sw,
                                       input int ad, input int lt, input int oe, input int fc,
                                       input int er);
    return {st[0], idx[2:0], bf[0], sw[0], ad[0], lt[0], oe[0], fc[15:0], er[0]};
  endfunction

  function automatic logic [25:0] dut_pack();
    return {blit_start, blit_row, blit_plane, buf_sel, frame_swap, panel_addr,
            panel_lat, panel_oe_n, frame_count, blit_err};
  endfunction

  // Timeline model. For plane k: done d = start + delay; BLANK at
  // max(d+1, first dark cycle of the previous display); LATCH one later;
  // OE low for BASE_ON<<plane cycles after LATCH; next start right after
  // LATCH while enabled, otherwise drain to IDLE where the index is zero.
  task automatic build(input scen_t sc);
    int e_prev, s, d, dl, bl, lt, w, idx, fc, bf, cnt, c_on;
    for (int c = 0; c < MAXC; c++) begin
      exp_start[c] = 0; exp_lat[c] = 0; exp_swap[c] = 0; exp_oe_n[c] = 1;
      exp_idx[c] = 0; exp_addr[c] = 0; exp_fc[c] = 0; exp_buf[c] = 0;
      drv_en[c] = 1'b0; drv_done[c] = 1'b0; in_shift[c] = 1'b0;
      drv_fr[c] = (sc.fr_mode == 2) ? 1'($urandom_range(1, 0)) : 1'(sc.fr_mode);
    end
    e_prev = 0; fc = 0; bf = 0; c_on = 0;
    for (int b = 0; b < 2; b++) begin
      cnt = (b == 0) ? sc.n1 : sc.n2;
      if (cnt == 0) break;
      if (b == 1) c_on = e_prev + 5;
      s = c_on + 1;
      idx = 0;
      for (int j = 0; j < cnt; j++) begin
        dl = (sc.dly == 0) ? int'($urandom_range(12, 1)) : sc.dly;
        d = s + dl;
        for (int c = s; c <= d && c < MAXC; c++) in_shift[c] = 1'b1;
        drv_done[d] = 1'b1;
        bl = (d + 1 > e_prev) ? d + 1 : e_prev;
        lt = bl + 1;
        w  = BASE_ON << (idx % 4);
        exp_start[s] = 1;
        exp_lat[lt]  = 1;
        for (int c = lt; c < MAXC; c++) exp_addr[c] = idx / 4;
        for (int c = lt + 1; c <= lt + w; c++) exp_oe_n[c] = 0;
        e_prev = lt + w + 1;
        if (idx == 7) begin
          fc = (fc + 1) & 16'hFFFF;
          for (int c = lt + 1; c < MAXC; c++) exp_fc[c] = fc;
          if (drv_fr[lt]) begin
            bf = bf ^ 1;
            for (int c = lt + 1; c < MAXC; c++) exp_buf[c] = bf;
            exp_swap[lt + 1] = 1;
          end
        end
        idx = (idx + 1) % 8;
        for (int c = lt + 1; c < MAXC; c++) exp_idx[c] = idx;
        if (j == cnt - 1) begin
          for (int c = c_on; c < s; c++) drv_en[c] = 1'b1;
          for (int c = e_prev; c < MAXC; c++) exp_idx[c] = 0;
        end
        s = lt + 1;
      end
    end
    run_len = e_prev + 10;
    if (sc.spur) begin
      for (int c = 0; c < run_len; c++)
        if (!in_shift[c] && $urandom_range(7, 0) == 0) drv_done[c] = 1'b1;
    end
  endtask

  task automatic do_reset(input string tag);
    core_rst = 1'b1; enable = 1'b1; blit_done = 1'b0; frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge core_clk);
      @(negedge core_clk);
      chk($sformatf("%s reset cyc%0d", tag, i), dut_pack(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0));
    end
  endtask

  task automatic drive(input int c);
    enable      = drv_en[c];
    blit_done   = drv_done[c];
    frame_ready = drv_fr[c];
  endtask

  // Runs one table entry; stop_at > 0 ends early (used for the abort test).
  task automatic run_scen(input int r, input int stop_at);
    int n_st, n_lt, limit;
    build(tbl[r]);
    do_reset($sformatf("s%0d", r));
    core_rst = 1'b0;
    drive(0);
    n_st = 0; n_lt = 0;
    limit = (stop_at > 0) ? stop_at : run_len - 1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge core_clk);
      @(negedge core_clk);
      chk($sformatf("s%0d c%0d {start,idx,buf,swap,addr,lat,oe_n,fc,err}", r, c), dut_pack(),
          pack(exp_start[c], exp_idx[c], exp_buf[c], exp_swap[c], exp_addr[c],
               exp_lat[c], exp_oe_n[c], exp_fc[c], 0));
      n_st += int'(blit_start === 1'b1);
      n_lt += int'(panel_lat === 1'b1);
      drive(c);
    end
    if (stop_at == 0) begin
      chk($sformatf("s%0d start count", r), n_st, tbl[r].exp_starts);
      chk($sformatf("s%0d latch count", r), n_lt, tbl[r].exp_lats);
      chk($sformatf("s%0d final frame_count", r), frame_count, tbl[r].exp_fc);
      $display("scenario %0d: %0d cycles, %0d starts, %0d latches, frame_count %0d",
               r, limit + 1, n_st, n_lt, frame_count);
    end
  endtask

  initial begin
    core_rst = 1'b1; enable = 1'b1; blit_done = 1'b0; frame_ready = 1'b0;

    //         n1  n2 dly fr spur starts lats fc
    tbl[0] = '{20,  0,  3, 0, 0,  20,   20,  2};  // fast responder
    tbl[1] = '{ 9,  0, 40, 0, 0,   9,    9,  1};  // slow responder
    tbl[2] = '{17,  0,  3, 1, 0,  17,   17,  2};  // constant frame_ready
    tbl[3] = '{15,  9,  3, 1, 0,  24,   24,  2};  // drop during (1,2), re-enable
    tbl[4] = '{24,  5,  0, 2, 1,  29,   29,  3};  // random delays/ready/noise
    tbl[5] = '{12,  0,  1, 1, 1,  12,   12,  1};  // done right after start

    for (int r = 0; r < NSCEN; r++) run_scen(r, 0);

    // Reset mid-shift of (1,0) while plane 3 is on the panel.
    run_scen(0, 30);
    core_rst = 1'b1;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("abort reset values", dut_pack(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0));
    core_rst = 1'b0; enable = 1'b0; blit_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge core_clk);
      @(negedge core_clk);
      chk($sformatf("abort idle cyc%0d", i), dut_pack(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0));
    end
    $display("abort sequence done");

    // Silent responder: the request is re-issued only with the watchdog.
    do_reset("wd");
    core_rst = 1'b0; enable = 1'b1; blit_done = 1'b0; frame_ready = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      logic exp_st, exp_err;
`ifdef LEDVIDEO_BLIT_TIMEOUT_EN
      exp_st  = (c == 1) || (c == 1 + TIMEOUT) || (c == 1 + 2 * TIMEOUT);
      exp_err = (c >= 1 + TIMEOUT);
`else
      exp_st  = (c == 1);
      exp_err = 1'b0;
`endif
      @(posedge core_clk);
      @(negedge core_clk);
      chk($sformatf("silent c%0d {start,row,plane,err,oe_n}", c),
          {blit_start, blit_row, blit_plane, blit_err, panel_oe_n},
          {exp_st, 1'b0, 2'b00, exp_err, 1'b1});
    end
    $display("silent responder sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
